mtl2_lcd_timing: RTL and testbench

//  Timing generator for the MTL2 800x480 LCD. Consumes the 33 MHz pixel clock and the lock flag

---
 rtl/mtl2_pkg.sv | 32 +++
 rtl/mtl2_sync2.sv | 25 ++
 rtl/mtl2_lcd_timing.sv | 180 ++++++++++++++++++
 tb/tb_mtl2_lcd_timing.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mtl2_pkg.sv
// Shared timing defaults, counter widths, pixel type and FSM state encoding
// for the MTL2 800x480 LCD timing generator.
package mtl2_pkg;

  localparam int unsigned H_ACTIVE_D  = 800;
  localparam int unsigned H_FP_D      = 210;
  localparam int unsigned H_SYNC_D    = 30;
  localparam int unsigned H_BP_D      = 16;
  localparam int unsigned V_ACTIVE_D  = 480;
  localparam int unsigned V_FP_D      = 22;
  localparam int unsigned V_SYNC_D    = 13;
  localparam int unsigned V_BP_D      = 10;
  localparam bit          SYNC_POL_D  = 1'b0;
  localparam int unsigned LOCK_WAIT_D = 1024;

  localparam int unsigned H_W    = 11;
  localparam int unsigned V_W    = 10;
  localparam int unsigned WAIT_W = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } lcd_state_e;

endpackage

// File: rtl/mtl2_sync2.sv
// Two-flop synchroniser for a single asynchronous level; output resets to 0.
module mtl2_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mtl2_lcd_timing.sv
// MTL2 LCD timing generator: waits for a stable PLL lock, then scans h/v,
// requests one pixel per active cycle and registers DE/HS/VS/RGB to the panel.
module mtl2_lcd_timing
  import mtl2_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_D,
  parameter int unsigned H_FP      = H_FP_D,
  parameter int unsigned H_SYNC    = H_SYNC_D,
  parameter int unsigned H_BP      = H_BP_D,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_D,
  parameter int unsigned V_FP      = V_FP_D,
  parameter int unsigned V_SYNC    = V_SYNC_D,
  parameter int unsigned V_BP      = V_BP_D,
  parameter bit          SYNC_POL  = SYNC_POL_D,
  parameter int unsigned LOCK_WAIT = LOCK_WAIT_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  input  logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic [23:0] lcd_rgb,
  output logic        running
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_WAIT - 1);

  if (H_TOTAL > (1 << H_W) || V_TOTAL > (1 << V_W) || H_ACTIVE > 1024 ||
      V_ACTIVE > 512 || LOCK_WAIT < 1 || LOCK_WAIT > (1 << WAIT_W)) begin : g_param_check
    $error("mtl2_lcd_timing: timing parameters do not fit the counters");
  end

  lcd_state_e        state_r;
  lcd_state_e        state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [H_W-1:0]    h_r;
  logic [V_W-1:0]    v_r;
  logic              lock_s;
  logic              run_s;
  logic              stay_s;
  logic              req_s;
  logic              hs_s;
  logic              vs_s;
  logic              de_r;
  logic              hs_r;
  logic              vs_r;
  rgb888_t           rgb_r;

  mtl2_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= WAIT_LOCK;
    else        state_r <= state_next_s;
  end

  // FSM next state: any loss of lock falls back to WAIT_LOCK
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lock_s) state_next_s = SETTLE;
        else        state_next_s = WAIT_LOCK;
      end
      SETTLE: begin
        if (!lock_s)                      state_next_s = WAIT_LOCK;
        else if (wait_cnt_r == WAIT_LAST) state_next_s = RUN;
        else                              state_next_s = SETTLE;
      end
      RUN: begin
        if (!lock_s) state_next_s = WAIT_LOCK;
        else         state_next_s = RUN;
      end
      default: state_next_s = WAIT_LOCK;
    endcase
  end

  // FSM outputs; stay_s means the scan continues past this edge
  always_comb begin
    run_s  = 1'b0;
    stay_s = 1'b0;
    case (state_r)
      RUN: begin
        run_s  = 1'b1;
        stay_s = lock_s;
      end
      default: begin
        run_s  = 1'b0;
        stay_s = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         wait_cnt_r <= '0;
    else if (state_r == SETTLE && lock_s) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    else                                wait_cnt_r <= '0;
  end

  // Scan counters, held at the origin outside an uninterrupted RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_r <= '0;
      v_r <= '0;
    end else if (!stay_s) begin
      h_r <= '0;
      v_r <= '0;
    end else if (32'(h_r) == H_TOTAL - 1) begin
      h_r <= '0;
      if (32'(v_r) == V_TOTAL - 1) v_r <= '0;
      else                         v_r <= v_r + V_W'(1);
    end else begin
      h_r <= h_r + H_W'(1);
      v_r <= v_r;
    end
  end

  always_comb begin
    req_s = 1'b0;
    hs_s  = 1'b0;
    vs_s  = 1'b0;
    if (run_s) begin
      req_s = (32'(h_r) < H_ACTIVE) && (32'(v_r) < V_ACTIVE);
      hs_s  = (32'(h_r) >= HS_START) && (32'(h_r) < HS_END);
      vs_s  = (32'(v_r) >= VS_START) && (32'(v_r) < VS_END);
    end else begin
      req_s = 1'b0;
      hs_s  = 1'b0;
      vs_s  = 1'b0;
    end
  end

  // Panel register: one clock behind the request, cleared on lock loss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_r  <= 1'b0;
      rgb_r <= '0;
      hs_r  <= ~SYNC_POL;
      vs_r  <= ~SYNC_POL;
    end else if (stay_s) begin
      de_r  <= req_s;
      rgb_r <= req_s ? rgb888_t'(pix_rgb) : '0;
      hs_r  <= hs_s ^ ~SYNC_POL;
      vs_r  <= vs_s ^ ~SYNC_POL;
    end else begin
      de_r  <= 1'b0;
      rgb_r <= '0;
      hs_r  <= ~SYNC_POL;
      vs_r  <= ~SYNC_POL;
    end
  end

  assign pix_req     = req_s;
  assign pix_x       = req_s ? h_r[9:0] : 10'd0;
  assign pix_y       = req_s ? v_r[8:0] : 9'd0;
  assign frame_start = run_s && (h_r == '0) && (v_r == '0);
  assign running     = run_s;
  assign lcd_de      = de_r;
  assign lcd_hs      = hs_r;
  assign lcd_vs      = vs_r;
  assign lcd_rgb     = rgb_r;

endmodule

// File: tb/tb_mtl2_lcd_timing.sv
// Bench for mtl2_lcd_timing: default-timing instance plus a tiny-timing instance,
// both checked every cycle against a lock-streak / frame-position model.
module tb_mtl2_lcd_timing;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lw;
    bit pol;
  } prm_t;

  typedef struct {
    bit          p1, p2;
    int          streak;
    bit          run;
    int          pos;
    bit          de, hs, vs;
    logic [23:0] rgb;
  } mst_t;

  logic clk = 1'b0;
  logic rst_n;
  logic pll_a, pll_b;

  logic        pix_req_a, frame_start_a, lcd_de_a, lcd_hs_a, lcd_vs_a, running_a;
  logic [9:0]  pix_x_a;
  logic [8:0]  pix_y_a;
  logic [23:0] pix_rgb_a, lcd_rgb_a;
  logic        pix_req_b, frame_start_b, lcd_de_b, lcd_hs_b, lcd_vs_b, running_b;
  logic [9:0]  pix_x_b;
  logic [8:0]  pix_y_b;
  logic [23:0] pix_rgb_b, lcd_rgb_b;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  prm_t pa = '{ha: 800, hfp: 210, hsw: 30, hbp: 16, va: 480, vfp: 22, vsw: 13, vbp: 10,
               lw: 1024, pol: 1'b0};
  prm_t pb = '{ha: 4, hfp: 1, hsw: 1, hbp: 1, va: 2, vfp: 1, vsw: 1, vbp: 1,
               lw: 8, pol: 1'b0};
  mst_t ma, mb, mn;

  int a_de_rise[$], a_de_fall[$], a_hs_fall[$], a_hs_rise[$];
  int b_fs[$], b_de_rise[$], b_vs_fall[$], b_vs_rise[$];
  int a_de_cnt = 0;
  logic [23:0] a_rgb805 = 24'h0;
  bit a_prev_de = 1'b0, a_prev_hs = 1'b1, b_prev_de = 1'b0, b_prev_vs = 1'b1;

  assign pix_rgb_a = {pix_x_a[7:0], pix_y_a[7:0], 8'hA5};
  assign pix_rgb_b = {pix_x_b[7:0], pix_y_b[7:0], 8'hA5};

  mtl2_lcd_timing u_dut_a (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_a),
    .pix_req(pix_req_a), .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_rgb(pix_rgb_a),
    .frame_start(frame_start_a), .lcd_de(lcd_de_a), .lcd_hs(lcd_hs_a), .lcd_vs(lcd_vs_a),
    .lcd_rgb(lcd_rgb_a), .running(running_a)
  );

  mtl2_lcd_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .LOCK_WAIT(8)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_b),
    .pix_req(pix_req_b), .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_rgb(pix_rgb_b),
    .frame_start(frame_start_b), .lcd_de(lcd_de_b), .lcd_hs(lcd_hs_b), .lcd_vs(lcd_vs_b),
    .lcd_rgb(lcd_rgb_b), .running(running_b)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] pat(input int h, input int v);
    logic [31:0] hh, vv;
    hh = h;
    vv = v;
    return {hh[7:0], vv[7:0], 8'hA5};
  endfunction

  function automatic mst_t mreset(input prm_t p);
    mst_t m;
    m.p1 = 1'b0; m.p2 = 1'b0; m.streak = 0; m.run = 1'b0; m.pos = 0;
    m.de = 1'b0; m.hs = ~p.pol; m.vs = ~p.pol; m.rgb = 24'h0;
    return m;
  endfunction

  // One clock of the model: lock must have been seen high (after two sync
  // stages) for LOCK_WAIT+1 consecutive edges; then the frame position advances.
  task automatic step(input prm_t p, input mst_t mi, input bit pll, output mst_t mo);
    int ht, vt, h, v;
    bit ls, act;
    ht = p.ha + p.hfp + p.hsw + p.hbp;
    vt = p.va + p.vfp + p.vsw + p.vbp;
    mo = mi;
    ls = mi.p2;
    mo.p2 = mi.p1;
    mo.p1 = pll;
    mo.streak = ls ? ((mi.streak < (1 << 20)) ? mi.streak + 1 : mi.streak) : 0;
    mo.run = (mo.streak >= p.lw + 1);
    if (mo.run && mi.run) begin
      h = mi.pos % ht;
      v = mi.pos / ht;
      act = (h < p.ha) && (v < p.va);
      mo.de  = act;
      mo.rgb = act ? pat(h, v) : 24'h0;
      mo.hs  = (h >= p.ha + p.hfp && h < p.ha + p.hfp + p.hsw) ? p.pol : ~p.pol;
      mo.vs  = (v >= p.va + p.vfp && v < p.va + p.vfp + p.vsw) ? p.pol : ~p.pol;
      mo.pos = (mi.pos + 1) % (ht * vt);
    end else begin
      mo.de = 1'b0; mo.rgb = 24'h0; mo.hs = ~p.pol; mo.vs = ~p.pol; mo.pos = 0;
    end
  endtask

  task automatic chk(input string t, input prm_t p, input mst_t m,
                     input logic req, input logic [9:0] x, input logic [8:0] y,
                     input logic fs, input logic de, input logic hs, input logic vs,
                     input logic [23:0] rgb, input logic run);
    int ht, h, v;
    bit act;
    ht  = p.ha + p.hfp + p.hsw + p.hbp;
    h   = m.pos % ht;
    v   = m.pos / ht;
    act = m.run && (h < p.ha) && (v < p.va);
    cmp({t, ".pix_req"}, req, act);
    cmp({t, ".pix_x"}, x, act ? h : 0);
    cmp({t, ".pix_y"}, y, act ? v : 0);
    cmp({t, ".frame_start"}, fs, m.run && (m.pos == 0));
    cmp({t, ".running"}, run, m.run);
    cmp({t, ".lcd_de"}, de, m.de);
    cmp({t, ".lcd_hs"}, hs, m.hs);
    cmp({t, ".lcd_vs"}, vs, m.vs);
    cmp({t, ".lcd_rgb"}, rgb, m.rgb);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      ma = mreset(pa);
      mb = mreset(pb);
    end else begin
      step(pa, ma, pll_a, mn);
      ma = mn;
      step(pb, mb, pll_b, mn);
      mb = mn;
    end
    #1;
    chk("a", pa, ma, pix_req_a, pix_x_a, pix_y_a, frame_start_a, lcd_de_a, lcd_hs_a,
        lcd_vs_a, lcd_rgb_a, running_a);
    chk("b", pb, mb, pix_req_b, pix_x_b, pix_y_b, frame_start_b, lcd_de_b, lcd_hs_b,
        lcd_vs_b, lcd_rgb_b, running_b);
    if (lcd_de_a && !a_prev_de) a_de_rise.push_back(cyc);
    if (!lcd_de_a && a_prev_de) a_de_fall.push_back(cyc);
    if (!lcd_hs_a && a_prev_hs) a_hs_fall.push_back(cyc);
    if (lcd_hs_a && !a_prev_hs) a_hs_rise.push_back(cyc);
    if (lcd_de_a) begin
      if (a_de_cnt == 805) a_rgb805 = lcd_rgb_a;
      a_de_cnt++;
    end
    if (frame_start_b) b_fs.push_back(cyc);
    if (lcd_de_b && !b_prev_de) b_de_rise.push_back(cyc);
    if (!lcd_vs_b && b_prev_vs) b_vs_fall.push_back(cyc);
    if (lcd_vs_b && !b_prev_vs) b_vs_rise.push_back(cyc);
    a_prev_de = lcd_de_a;
    a_prev_hs = lcd_hs_a;
    b_prev_de = lcd_de_b;
    b_prev_vs = lcd_vs_b;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rises;
    rst_n = 1'b0;
    pll_a = 1'b1;
    pll_b = 1'b1;
    repeat (4) @(negedge clk);
    cmp("rst.lcd_de", lcd_de_a, 1'b0);
    cmp("rst.lcd_hs", lcd_hs_a, 1'b1);
    cmp("rst.lcd_vs", lcd_vs_a, 1'b1);
    cmp("rst.lcd_rgb", lcd_rgb_a, 24'h0);
    cmp("rst.running", running_a, 1'b0);
    cmp("rst.pix_req", pix_req_a, 1'b0);
    cmp("rst.frame_start", frame_start_a, 1'b0);
    rst_n = 1'b1;

    // 2 sync edges + 1 edge into SETTLE + LOCK_WAIT counted edges
    n = 0;
    while (n < 3000 && running_a !== 1'b1) begin @(posedge clk); #1; n++; end
    cmp("lock_to_run_clks", n, 1027);
    cmp("first.frame_start", frame_start_a, 1'b1);
    cmp("first.pix_req", pix_req_a, 1'b1);

    n = 0;
    while (n < 5000 && !(pix_y_a == 9'd2 && pix_x_a == 10'd400)) begin
      @(negedge clk);
      n++;
    end
    cmp("drop_point_reached", (n < 5000), 1'b1);
    pll_a = 1'b0;
    n = 0;
    while (n < 10 && running_a !== 1'b0) begin @(posedge clk); #1; n++; end
    cmp("drop_to_idle_clks", n, 3);
    cmp("drop.lcd_de", lcd_de_a, 1'b0);
    cmp("drop.lcd_hs", lcd_hs_a, 1'b1);
    cmp("drop.lcd_vs", lcd_vs_a, 1'b1);

    cmp("line.queues", (a_de_rise.size() >= 2 && a_de_fall.size() >= 1 &&
                        a_hs_fall.size() >= 1 && a_hs_rise.size() >= 1), 1'b1);
    if (a_de_rise.size() >= 2 && a_de_fall.size() >= 1 &&
        a_hs_fall.size() >= 1 && a_hs_rise.size() >= 1) begin
      cmp("line.de_high", a_de_fall[0] - a_de_rise[0], 800);
      cmp("line.hs_low", a_hs_rise[0] - a_hs_fall[0], 30);
      cmp("line.de_fall_to_hs_fall", a_hs_fall[0] - a_de_fall[0], 210);
      cmp("line.period", a_de_rise[1] - a_de_rise[0], 1056);
    end
    cmp("pixel_x5_y1.rgb", a_rgb805, 24'h0501A5);

    @(negedge clk);
    pll_a = 1'b1;
    repeat (500) @(negedge clk);
    cmp("settle.running", running_a, 1'b0);
    pll_a = 1'b0;
    @(negedge clk);
    pll_a = 1'b1;
    n = 0;
    while (n < 3000 && running_a !== 1'b1) begin @(posedge clk); #1; n++; end
    cmp("glitch_relock_clks", n, 1027);
    cmp("relock.frame_start", frame_start_a, 1'b1);
    cmp("relock.pix_x", pix_x_a, 10'd0);
    cmp("relock.pix_y", pix_y_a, 9'd0);
    repeat (1200) @(negedge clk);

    cmp("small.queues", (b_fs.size() >= 3 && b_vs_fall.size() >= 1 &&
                         b_vs_rise.size() >= 1), 1'b1);
    if (b_fs.size() >= 3 && b_vs_fall.size() >= 1 && b_vs_rise.size() >= 1) begin
      cmp("small.frame_period0", b_fs[1] - b_fs[0], 35);
      cmp("small.frame_period1", b_fs[2] - b_fs[1], 35);
      rises = 0;
      foreach (b_de_rise[i]) if (b_de_rise[i] > b_fs[0] && b_de_rise[i] <= b_fs[1]) rises++;
      cmp("small.de_lines", rises, 2);
      cmp("small.vs_low", b_vs_rise[0] - b_vs_fall[0], 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
